sw_debounce: RTL

//  Conditions the raw board slide-switch/button bank before it reaches the seven-segment counter (ss_cntr).
//  - Synchronises each bit into clk.
//  - Debounces each bit with a shared sample-tick prescaler.
//  - Emits clean levels plus one-cycle rise/fall/change pulses that ss_cntr consumes in place of raw sw.

---
 rtl/board_pkg.sv | 13 +
 rtl/sw_db_chan.sv | 51 +++++
 rtl/sw_debounce.sv | 77 +++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared board-level constants for the switch conditioning path feeding ss_cntr.
package board_pkg;

  localparam int SW_W      = 8;
  localparam int SW_DIV    = 10000;
  localparam int SW_STABLE = 4;

  // Counter width that still works when the terminal count is 0 or 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_db_chan.sv
// One debounce channel: counts disagreeing sample ticks and accepts a new level
// after STABLE of them in a row, emitting a single-cycle rise or fall pulse.
module sw_db_chan
  import board_pkg::*;
#(
  parameter int STABLE = SW_STABLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic s,
  output logic db,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int            CW   = cnt_width(STABLE);
  localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

  logic [CW-1:0] scnt;

  // Lets the top register sw_chg in the same cycle the pulses appear.
  assign accept = tick && (s != db) && (scnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt <= '0;
      db   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        // Any agreeing sample restarts the count, which rejects bounce.
        if (s == db) begin
          scnt <= '0;
        end else if (scnt == LAST) begin
          db   <= s;
          scnt <= '0;
          rise <= s;
          fall <= ~s;
        end else begin
          scnt <= scnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Switch bank conditioner: two-flop synchroniser, shared sample prescaler and
// one debounce channel per bit, with a combined change pulse.
module sw_debounce
  import board_pkg::*;
#(
  parameter int W          = SW_W,
  parameter int DIV        = SW_DIV,
  parameter int STABLE     = SW_STABLE,
  parameter int ACTIVE_LOW = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw_raw,
  output logic [W-1:0] sw_db,
  output logic [W-1:0] sw_rise,
  output logic [W-1:0] sw_fall,
  output logic         sw_chg
);

  localparam int            PW    = cnt_width(DIV);
  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
  localparam logic [W-1:0]  INV   = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

  logic [PW-1:0] pcnt;
  logic          tick;
  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [W-1:0]  s;
  logic [W-1:0]  accept;

  assign tick = (pcnt == PLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
    end
  end

  // Reset to the inactive pin level so the logical level starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= INV;
      sync2 <= INV;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ INV;

  for (genvar i = 0; i < W; i++) begin : g_chan
    sw_db_chan #(
      .STABLE(STABLE)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .s      (s[i]),
      .db     (sw_db[i]),
      .rise   (sw_rise[i]),
      .fall   (sw_fall[i]),
      .accept (accept[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_chg <= 1'b0;
    end else begin
      sw_chg <= |accept;
    end
  end

endmodule
